lcd_cmd_scheduler: RTL and testbench



---
 rtl/lcd_cmd_scheduler_if.sv | 13 +
 rtl/lcd_cmd_scheduler.sv | 155 +++++++++++++++
 tb/tb_lcd_cmd_scheduler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_scheduler_if.sv
// Requester-side command handshake: one (op, data) word offered per cycle,
// transferred on an edge where valid and ready are both high.
interface lcd_cmd_scheduler_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic [3:0]        op;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output op, output data, input ready);
  modport slave  (input valid, input op, input data, output ready);
endinterface

// File: rtl/lcd_cmd_scheduler.sv
// Arbitrates two command requesters into a small queue and issues entries
// one at a time to the LCD command unit, with CLEAR flush and ack timeout.
module lcd_cmd_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACK_TMO = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  lcd_cmd_scheduler_if.slave     a,
  lcd_cmd_scheduler_if.slave     b,
  input  logic                   rdy_cmd,
  output logic [3:0]             op_cmd,
  output logic [DATA_W-1:0]      data_cmd,
  output logic                   cmd_valid,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   tmo_err
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(ACK_TMO + 2);
  localparam logic [3:0]  OP_CLEAR = 4'd0;
  localparam logic [3:0]  OP_NOP   = 4'd15;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               clear_pend;
  logic               rr_a;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               grant_a, grant_b, has_room;
  logic               xfer_a, xfer_b, xfer;
  logic [3:0]         sel_op;
  logic [DATA_W-1:0]  sel_data;
  logic               clear_req, push, do_flush, issue, pop;

  // rr_a set means A wins the next contested cycle; reset favours B.
  assign grant_a  = a.valid & (~b.valid | rr_a);
  assign grant_b  = b.valid & (~a.valid | ~rr_a);
  assign has_room = count < CNT_W'(DEPTH);
  assign a.ready  = grant_a & ((a.op == OP_CLEAR) | has_room);
  assign b.ready  = grant_b & ((b.op == OP_CLEAR) | has_room);

  assign xfer_a    = a.valid & a.ready;
  assign xfer_b    = b.valid & b.ready;
  assign xfer      = xfer_a | xfer_b;
  assign sel_op    = xfer_a ? a.op   : b.op;
  assign sel_data  = xfer_a ? a.data : b.data;
  assign clear_req = xfer & (sel_op == OP_CLEAR);
  assign push      = xfer & (sel_op != OP_CLEAR) & (sel_op != OP_NOP);
  assign do_flush  = clear_req & ~clear_pend;

  assign issue   = (state == IDLE) & rdy_cmd & (clear_pend | (count != '0));
  assign pop     = issue & ~clear_pend;
  assign pending = count;

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: sel_op, data: sel_data};
    end
  end

  // Queue pointers, occupancy, pending CLEAR and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      clear_pend <= 1'b0;
      rr_a       <= 1'b0;
    end else begin
      if (xfer & a.valid & b.valid) begin
        rr_a <= xfer_b;
      end
      if (do_flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        clear_pend <= 1'b1;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (issue & clear_pend) begin
          clear_pend <= 1'b0;
        end
      end
    end
  end

  // Issue sequencer: strobe, wait for the unit to go busy, then idle again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_cmd    <= OP_NOP;
      data_cmd  <= '0;
      cmd_valid <= 1'b0;
      tmo_cnt   <= '0;
      tmo_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            cmd_valid <= 1'b1;
            if (clear_pend) begin
              op_cmd   <= OP_CLEAR;
              data_cmd <= '0;
            end else begin
              op_cmd   <= mem[rd_ptr].op;
              data_cmd <= mem[rd_ptr].data;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cmd_valid <= 1'b0;
          tmo_cnt   <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!rdy_cmd) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TMO_W'(ACK_TMO)) begin
            tmo_err <= 1'b1;
            op_cmd  <= OP_NOP;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (rdy_cmd) begin
            op_cmd <= OP_NOP;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler with a simple LCD command unit model
// that logs every issued command.
module tb_lcd_cmd_scheduler;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ACK_TMO = 255;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  lcd_cmd_scheduler_if #(.DATA_W(DATA_W)) a_if ();
  lcd_cmd_scheduler_if #(.DATA_W(DATA_W)) b_if ();

  logic                   rdy_cmd;
  logic [3:0]             op_cmd;
  logic [DATA_W-1:0]      data_cmd;
  logic                   cmd_valid;
  logic [$clog2(DEPTH):0] pending;
  logic                   tmo_err;

  lcd_cmd_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACK_TMO(ACK_TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a_if),
    .b         (b_if),
    .rdy_cmd   (rdy_cmd),
    .op_cmd    (op_cmd),
    .data_cmd  (data_cmd),
    .cmd_valid (cmd_valid),
    .pending   (pending),
    .tmo_err   (tmo_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // LCD unit model: goes busy for busy_cycles after each strobe unless stuck.
  int          busy_cycles = 10;
  int          busy_cnt    = 0;
  bit          stuck       = 1'b0;
  bit          force_busy  = 1'b0;
  bit          prev_cv     = 1'b0;
  logic [35:0] log_q[$];

  assign rdy_cmd = (busy_cnt == 0) && !force_busy;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      chk_eq("cv_one_cycle", 64'(prev_cv), 64'd0);
      log_q.push_back({op_cmd, data_cmd});
      if (!stuck) busy_cnt = busy_cycles;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    prev_cv = cmd_valid;
  end

  task automatic push(input bit use_b, input logic [3:0] op, input logic [31:0] data);
    int k = 0;
    logic rdy;
    if (use_b) begin b_if.valid = 1'b1; b_if.op = op; b_if.data = data; end
    else       begin a_if.valid = 1'b1; a_if.op = op; a_if.data = data; end
    @(negedge clk);
    rdy = use_b ? b_if.ready : a_if.ready;
    while (!rdy && k < 200) begin
      @(negedge clk);
      rdy = use_b ? b_if.ready : a_if.ready;
      k++;
    end
    chk_eq("push_ready", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk_eq(tag, 64'(log_q.size()), 64'(n));
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [3:0] op, input logic [31:0] data);
    logic [35:0] e;
    e = (idx < log_q.size()) ? log_q[idx] : 36'hx_ffff_ffff;
    chk_eq(tag, 64'(e), 64'({op, data}));
  endtask

  initial begin
    logic [3:0]  exp_op  [4];
    logic [31:0] exp_dat [4];

    // Reset with A already requesting.
    rst = 1'b0;
    a_if.valid = 1'b1; a_if.op = 4'd1; a_if.data = 32'd3;
    b_if.valid = 1'b0; b_if.op = 4'd0; b_if.data = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_op_cmd",    64'(op_cmd),    64'd15);
    chk_eq("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk_eq("rst_pending",   64'(pending),   64'd0);
    chk_eq("rst_tmo_err",   64'(tmo_err),   64'd0);
    chk_eq("rst_a_ready",   64'(a_if.ready), 64'd1);
    chk_eq("rst_b_ready",   64'(b_if.ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    chk_eq("lat_pending_n",   64'(pending),   64'd1);
    chk_eq("lat_cv_n",        64'(cmd_valid), 64'd0);
    @(posedge clk); #1;
    chk_eq("lat_cv_n1",       64'(cmd_valid), 64'd1);
    chk_eq("lat_op_n1",       64'(op_cmd),    64'd1);
    chk_eq("lat_data_n1",     64'(data_cmd),  64'd3);
    chk_eq("lat_pending_n1",  64'(pending),   64'd0);
    @(posedge clk); #1;
    chk_eq("lat_cv_n2",       64'(cmd_valid), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk_eq("first_log_size",  64'(log_q.size()), 64'd1);
    chk_log("first_cmd", 0, 4'd1, 32'd3);
    chk_eq("first_op_nop",    64'(op_cmd),   64'd15);
    chk_eq("first_data_hold", 64'(data_cmd), 64'd3);

    // Contention: both requesters held, grants must alternate B,A,B,A.
    log_q.delete();
    busy_cycles = 3;
    for (int i = 0; i < 4; i++) begin
      a_if.valid = 1'b1; a_if.op = 4'd1; a_if.data = 32'(100 + i);
      b_if.valid = 1'b1; b_if.op = 4'd2; b_if.data = 32'(200 + i);
      @(negedge clk);
      chk_eq($sformatf("rr_a_ready_%0d", i), 64'(a_if.ready), 64'(i % 2));
      chk_eq($sformatf("rr_b_ready_%0d", i), 64'(b_if.ready), 64'((i + 1) % 2));
      @(posedge clk); #1;
    end
    a_if.valid = 1'b0; b_if.valid = 1'b0;
    wait_log("rr_wait", 4, 100);
    exp_op  = '{4'd2, 4'd1, 4'd2, 4'd1};
    exp_dat = '{32'd200, 32'd101, 32'd202, 32'd103};
    for (int i = 0; i < 4; i++) chk_log($sformatf("rr_issue_%0d", i), i, exp_op[i], exp_dat[i]);
    repeat (10) @(posedge clk);

    // Full queue: unit held busy, fifth push must stall until an issue.
    #1;
    log_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_if.valid = 1'b1; a_if.op = 4'd1; a_if.data = 32'(i);
      @(negedge clk);
      chk_eq($sformatf("full_ready_%0d", i), 64'(a_if.ready), 64'(i < 4));
      if (i < 4) begin @(posedge clk); #1; end
    end
    chk_eq("full_pending", 64'(pending), 64'd4);
    repeat (3) @(negedge clk);
    chk_eq("full_stall", 64'(a_if.ready), 64'd0);
    force_busy = 1'b0;
    for (int k = 0; k < 20 && a_if.ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk_eq("full_ready_back", 64'(a_if.ready), 64'd1);
    chk_eq("full_first_cv",   64'(cmd_valid),  64'd1);
    chk_eq("full_first_data", 64'(data_cmd),   64'd0);
    chk_eq("full_pend_3",     64'(pending),    64'd3);
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    chk_eq("full_pend_4",     64'(pending),    64'd4);
    wait_log("full_wait", 5, 200);
    for (int i = 0; i < 5; i++) chk_log($sformatf("full_issue_%0d", i), i, 4'd1, 32'(i));
    repeat (10) @(posedge clk);

    // CLEAR while one command is in flight and three are queued.
    #1;
    log_q.delete();
    busy_cycles = 20;
    for (int i = 0; i < 4; i++) push(1'b0, 4'd3, 32'h30 + 32'(i));
    chk_eq("clr_pend_before", 64'(pending), 64'd3);
    chk_eq("clr_inflight",    64'(log_q.size()), 64'd1);
    push(1'b1, 4'd0, 32'h99);
    chk_eq("clr_pend_after",  64'(pending), 64'd0);
    wait_log("clr_wait", 2, 100);
    repeat (30) @(posedge clk);
    #1;
    chk_eq("clr_log_size", 64'(log_q.size()), 64'd2);
    chk_log("clr_issue_0", 0, 4'd3, 32'h30);
    chk_log("clr_issue_1", 1, 4'd0, 32'h0);
    busy_cycles = 3;

    // Timeout: unit never drops ready after the strobe.
    log_q.delete();
    stuck = 1'b1;
    a_if.valid = 1'b1; a_if.op = 4'd5; a_if.data = 32'h50;
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    for (int k = 0; k < 10 && cmd_valid !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk_eq("tmo_issue_cv", 64'(cmd_valid), 64'd1);
    a_if.valid = 1'b1; a_if.data = 32'h51;
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    repeat (ACK_TMO) @(posedge clk);
    #1;
    chk_eq("tmo_err_early", 64'(tmo_err), 64'd0);
    @(posedge clk); #1;
    chk_eq("tmo_err_set",   64'(tmo_err), 64'd1);
    stuck = 1'b0;
    @(posedge clk); #1;
    chk_eq("tmo_next_cv",   64'(cmd_valid), 64'd1);
    chk_eq("tmo_next_op",   64'(op_cmd),    64'd5);
    chk_eq("tmo_next_data", 64'(data_cmd),  64'h51);
    repeat (10) @(posedge clk);
    #1;
    chk_eq("tmo_sticky",    64'(tmo_err), 64'd1);
    chk_eq("tmo_log_size",  64'(log_q.size()), 64'd2);

    // Wrap: ten commands through the four-entry queue.
    log_q.delete();
    busy_cycles = 2;
    for (int i = 0; i < 10; i++) push(1'b1, 4'((i % 14) + 1), 32'hA000_0000 + 32'(i));
    wait_log("wrap_wait", 10, 400);
    for (int i = 0; i < 10; i++)
      chk_log($sformatf("wrap_issue_%0d", i), i, 4'((i % 14) + 1), 32'hA000_0000 + 32'(i));
    repeat (10) @(posedge clk);

    // Reset mid-operation drops queued commands and clears tmo_err.
    #1;
    log_q.delete();
    force_busy = 1'b1;
    push(1'b0, 4'd7, 32'h70);
    push(1'b0, 4'd7, 32'h71);
    chk_eq("mrst_pend_before", 64'(pending), 64'd2);
    rst = 1'b0;
    #2;
    chk_eq("mrst_pending", 64'(pending), 64'd0);
    chk_eq("mrst_tmo_err", 64'(tmo_err), 64'd0);
    chk_eq("mrst_op_cmd",  64'(op_cmd),  64'd15);
    @(negedge clk);
    rst = 1'b1;
    force_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_eq("mrst_no_issue", 64'(log_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
